// File: rtl/sniffer_pkg.sv
// Shared definitions for the sniffer datapath: character codes, token FSM
// states and the byte classification helper.
package sniffer_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIGN = 2'd1,
    NUM  = 2'd2
  } tok_state_t;

  typedef struct packed {
    logic is_number;
    logic is_white;
    logic is_sign;
  } char_class_t;

  // Map one ASCII byte onto its digit / whitespace / sign flags.
  function automatic char_class_t classify(input logic [7:0] ch);
    char_class_t c;
    c.is_number = (ch >= CH_0) && (ch <= CH_9);
    c.is_white  = (ch == CH_SP) || (ch == CH_TAB) || (ch == CH_LF) || (ch == CH_CR);
    c.is_sign   = (ch == CH_MINUS);
    return c;
  endfunction

endpackage

// File: rtl/sniff_token_window_if.sv
// Byte-in / window-and-token-out bundle of the token window block.
// The byte source drives through master, the window block sits on slave.
interface sniff_token_window_if #(
  parameter int DEPTH = 12,
  parameter int VAL_W = 16,
  parameter int LEN_W = 4
);

  logic             enable;
  logic             flush;
  logic [7:0]       data_in;
  logic [7:0]       data_out;
  logic [DEPTH-1:0] is_number_out;
  logic [DEPTH-1:0] is_white_out;
  logic             tok_valid;
  logic [VAL_W-1:0] tok_value;
  logic             tok_neg;
  logic [LEN_W-1:0] tok_len;
  logic             tok_ovf;

  modport master (
    output enable, flush, data_in,
    input  data_out, is_number_out, is_white_out,
    input  tok_valid, tok_value, tok_neg, tok_len, tok_ovf
  );

  modport slave (
    input  enable, flush, data_in,
    output data_out, is_number_out, is_white_out,
    output tok_valid, tok_value, tok_neg, tok_len, tok_ovf
  );

endinterface

// File: rtl/sniff_char_classifier.sv
// Combinational byte-to-flags classifier.
module sniff_char_classifier
  import sniffer_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls
);

  assign cls = classify(ch);

endmodule

// File: rtl/sniff_token_window.sv
// Sliding character window with per-slot digit/whitespace flags, plus a
// signed decimal token tracker that converts each number to binary and
// reports it with a one-cycle pulse.
module sniff_token_window
  import sniffer_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int VAL_W = 16,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sniff_token_window_if.slave  bus
);

  localparam logic [VAL_W+3:0] ACC_MAX = {4'b0000, {VAL_W{1'b1}}};
  localparam logic [VAL_W+3:0] TEN     = (VAL_W+4)'(10);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  char_class_t      cls_s;
  logic [7:0]       win_r [DEPTH];
  logic [DEPTH-1:0] num_r;
  logic [DEPTH-1:0] white_r;

  tok_state_t       state_r, state_n;
  logic [VAL_W-1:0] acc_r, acc_n;
  logic [LEN_W-1:0] len_r, len_n;
  logic             neg_r, neg_n;
  logic             ovf_r, ovf_n;
  logic             emit_s;
  logic [VAL_W+3:0] prod_s;
  logic [VAL_W-1:0] digit_s;

  logic             tok_valid_r;
  logic [VAL_W-1:0] tok_value_r;
  logic             tok_neg_r;
  logic [LEN_W-1:0] tok_len_r;
  logic             tok_ovf_r;

  sniff_char_classifier u_classifier (
    .ch  (bus.data_in),
    .cls (cls_s)
  );

  // Digit value and the widened acc*10+d; the extra 4 bits expose overflow.
  assign digit_s = VAL_W'(bus.data_in[3:0]);
  assign prod_s  = ({4'b0000, acc_r} * TEN) + (VAL_W+4)'(bus.data_in[3:0]);

  // Shift the new byte and its flags into slot 0 on every enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_r[i] <= 8'h00;
      num_r   <= '0;
      white_r <= '0;
    end else if (bus.enable) begin
      win_r[0] <= bus.data_in;
      for (int i = 1; i < DEPTH; i++) win_r[i] <= win_r[i-1];
      num_r   <= {num_r[DEPTH-2:0], cls_s.is_number};
      white_r <= {white_r[DEPTH-2:0], cls_s.is_white};
    end
  end

  // Token FSM next-state: accumulate digits, decide when a token closes.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    len_n   = len_r;
    neg_n   = neg_r;
    ovf_n   = ovf_r;
    emit_s  = 1'b0;
    if (bus.enable) begin
      case (state_r)
        IDLE: begin
          if (cls_s.is_sign) begin
            state_n = SIGN;
          end else if (cls_s.is_number) begin
            state_n = NUM;
            acc_n   = digit_s;
            len_n   = LEN_ONE;
            neg_n   = 1'b0;
            ovf_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
        SIGN: begin
          if (cls_s.is_number) begin
            state_n = NUM;
            acc_n   = digit_s;
            len_n   = LEN_ONE;
            neg_n   = 1'b1;
            ovf_n   = 1'b0;
          end else if (cls_s.is_sign) begin
            state_n = SIGN;
          end else begin
            state_n = IDLE;
          end
        end
        NUM: begin
          if (cls_s.is_number) begin
            if (prod_s > ACC_MAX) begin
              acc_n = {VAL_W{1'b1}};
              ovf_n = 1'b1;
            end else begin
              acc_n = prod_s[VAL_W-1:0];
            end
            if (len_r != LEN_MAX) begin
              len_n = len_r + LEN_ONE;
            end else begin
              len_n = len_r;
            end
          end else begin
            // A '-' closes this token and opens the next one at once.
            emit_s = 1'b1;
            if (cls_s.is_sign) begin
              state_n = SIGN;
              neg_n   = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (bus.flush) begin
      // End of stream: an open number is reported, a dangling sign is dropped.
      emit_s  = (state_r == NUM);
      state_n = IDLE;
    end else begin
      state_n = state_r;
    end
  end

  // Token FSM state and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= '0;
      len_r   <= '0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      acc_r   <= acc_n;
      len_r   <= len_n;
      neg_r   <= neg_n;
      ovf_r   <= ovf_n;
    end
  end

  // Token report: pulse valid, latch the fields until the next emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_valid_r <= 1'b0;
      tok_value_r <= '0;
      tok_neg_r   <= 1'b0;
      tok_len_r   <= '0;
      tok_ovf_r   <= 1'b0;
    end else begin
      tok_valid_r <= emit_s;
      if (emit_s) begin
        tok_value_r <= acc_r;
        tok_neg_r   <= neg_r;
        tok_len_r   <= len_r;
        tok_ovf_r   <= ovf_r;
      end
    end
  end

  assign bus.data_out      = win_r[DEPTH-1];
  assign bus.is_number_out = num_r;
  assign bus.is_white_out  = white_r;
  assign bus.tok_valid     = tok_valid_r;
  assign bus.tok_value     = tok_value_r;
  assign bus.tok_neg       = tok_neg_r;
  assign bus.tok_len       = tok_len_r;
  assign bus.tok_ovf       = tok_ovf_r;

endmodule

// File: tb/tb_sniff_token_window.sv
// Scoreboard bench for sniff_token_window: directed streams plus random
// stimulus, checked against a token/window model built from the stream.
module tb_sniff_token_window;

  localparam int DEPTH = 12;
  localparam int VAL_W = 16;
  localparam int LEN_W = 4;
  localparam longint VMAX = (longint'(1) << VAL_W) - 1;
  localparam longint LMAX = (longint'(1) << LEN_W) - 1;

  typedef struct {
    longint value;
    bit     neg;
    longint len;
    bit     ovf;
    longint due;
  } tok_t;

  typedef struct {
    logic [7:0] b;
    longint     due;
  } samp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  tok_t   exp_q[$];
  tok_t   seen_q[$];
  samp_t  hist[$];
  int     digs[$];
  bit     m_neg;
  bit     prev_minus;
  longint last_val = 0, last_len = 0;
  bit     last_neg = 1'b0, last_ovf = 1'b0;

  sniff_token_window_if #(.DEPTH(DEPTH), .VAL_W(VAL_W), .LEN_W(LEN_W)) bus ();

  sniff_token_window #(.DEPTH(DEPTH), .VAL_W(VAL_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_digit(input logic [7:0] b);
    return (b >= 8'd48) && (b <= 8'd57);
  endfunction

  function automatic bit is_space(input logic [7:0] b);
    return (b == 8'd32) || (b == 8'd9) || (b == 8'd10) || (b == 8'd13);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Close the pending digit run into an expected token due next cycle.
  task automatic emit_model();
    tok_t   t;
    longint v = 0;
    bit     o = 1'b0;
    foreach (digs[i]) begin
      v = v * 10 + digs[i];
      if (v > VMAX) begin
        v = VMAX;
        o = 1'b1;
      end
    end
    t.value = v;
    t.neg   = m_neg;
    t.len   = (digs.size() > LMAX) ? LMAX : digs.size();
    t.ovf   = o;
    t.due   = cyc + 1;
    exp_q.push_back(t);
    digs.delete();
  endtask

  // Present one input cycle and update the reference model.
  task automatic drive(input logic [7:0] b, input bit en, input bit fl);
    @(posedge clk);
    #2;
    bus.data_in = b;
    bus.enable  = en;
    bus.flush   = fl;
    if (en) begin
      hist.push_back('{b, cyc + 1});
      while (hist.size() > DEPTH + 2) void'(hist.pop_front());
      if (is_digit(b)) begin
        if (digs.size() == 0) m_neg = prev_minus;
        digs.push_back(int'(b) - 48);
      end else if (digs.size() != 0) begin
        emit_model();
      end
      prev_minus = (b == 8'h2D);
    end else if (fl) begin
      if (digs.size() != 0) emit_model();
      prev_minus = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom_range(32, 126)), 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    digs.delete();
    prev_minus = 1'b0;
    m_neg      = 1'b0;
    last_val   = 0;
    last_len   = 0;
    last_neg   = 1'b0;
    last_ovf   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_out"},  bus.data_out, 0);
    check({tag, "_is_number"}, bus.is_number_out, 0);
    check({tag, "_is_white"},  bus.is_white_out, 0);
    check({tag, "_tok_valid"}, bus.tok_valid, 0);
    check({tag, "_tok_value"}, bus.tok_value, 0);
    check({tag, "_tok_neg"},   bus.tok_neg, 0);
    check({tag, "_tok_len"},   bus.tok_len, 0);
    check({tag, "_tok_ovf"},   bus.tok_ovf, 0);
  endtask

  // Monitor: window contents every cycle, token reports against the scoreboard.
  always @(negedge clk) begin : monitor
    tok_t             t;
    logic [7:0]       eb;
    logic [7:0]       eold;
    logic [DEPTH-1:0] enum_f;
    logic [DEPTH-1:0] ewh_f;
    int               start;
    int               idx;
    if (!rst) begin
      start = hist.size() - 1;
      if (hist.size() > 0 && hist[hist.size()-1].due > cyc) start = start - 1;
      eold = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        idx       = start - i;
        eb        = (idx >= 0) ? hist[idx].b : 8'h00;
        enum_f[i] = is_digit(eb);
        ewh_f[i]  = is_space(eb);
        if (i == DEPTH - 1) eold = eb;
      end
      check("data_out", bus.data_out, eold);
      check("is_number_out", bus.is_number_out, enum_f);
      check("is_white_out", bus.is_white_out, ewh_f);
      if (bus.tok_valid) begin
        seen_q.push_back('{bus.tok_value, bus.tok_neg, bus.tok_len, bus.tok_ovf, cyc});
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        t = exp_q.pop_front();
        check("tok_valid", bus.tok_valid, 1);
        check("tok_value", bus.tok_value, t.value);
        check("tok_neg", bus.tok_neg, t.neg);
        check("tok_len", bus.tok_len, t.len);
        check("tok_ovf", bus.tok_ovf, t.ovf);
        last_val = t.value;
        last_neg = t.neg;
        last_len = t.len;
        last_ovf = t.ovf;
      end else begin
        check("tok_valid_idle", bus.tok_valid, 0);
        check("tok_value_hold", bus.tok_value, last_val);
        check("tok_len_hold", bus.tok_len, last_len);
      end
    end
  end

  initial begin
    int exp_v[5];
    int exp_l[5];
    bit exp_n[5];
    logic [7:0] ch;
    bit en;

    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.flush   = 1'b0;
    bus.data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mixed stream of letters, whitespace, numbers and a '-' terminator.
    seen_q.delete();
    send_str("pp2p 1h3c  traas20-02540kkkk");
    idle(3);
    exp_v = '{2, 1, 3, 20, 2540};
    exp_l = '{1, 1, 1, 2, 5};
    exp_n = '{0, 0, 0, 0, 1};
    check("s1_count", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
      check($sformatf("s1_val%0d", i), seen_q[i].value, exp_v[i]);
      check($sformatf("s1_len%0d", i), seen_q[i].len, exp_l[i]);
      check($sformatf("s1_neg%0d", i), seen_q[i].neg, exp_n[i]);
    end

    // Overflow saturates; the next token starts clean.
    seen_q.delete();
    send_str("70000 5 ");
    idle(2);
    check("ovf_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("ovf_value", seen_q[0].value, 16'hFFFF);
      check("ovf_flag", seen_q[0].ovf, 1);
      check("ovf_len", seen_q[0].len, 5);
      check("after_ovf_value", seen_q[1].value, 5);
      check("after_ovf_flag", seen_q[1].ovf, 0);
    end

    // Signs without digits emit nothing; flush closes a negative number.
    seen_q.delete();
    send_str("--x-7");
    drive(8'h00, 1'b0, 1'b1);
    idle(2);
    check("flush_count", seen_q.size(), 1);
    if (seen_q.size() == 1) begin
      check("flush_value", seen_q[0].value, 7);
      check("flush_neg", seen_q[0].neg, 1);
      check("flush_len", seen_q[0].len, 1);
    end

    // Enable gaps inside a number freeze everything.
    seen_q.delete();
    drive("1", 1'b1, 1'b0);
    drive("z", 1'b0, 1'b0);
    drive("9", 1'b0, 1'b0);
    drive("2", 1'b1, 1'b0);
    drive(" ", 1'b1, 1'b0);
    idle(2);
    check("gap_count", seen_q.size(), 1);
    if (seen_q.size() == 1) check("gap_value", seen_q[0].value, 12);

    // Async reset mid-token discards it and clears every output.
    seen_q.delete();
    send_str("45");
    @(posedge clk);
    #3;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.flush  = 1'b0;
    model_reset();
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_str(" ");
    idle(3);
    check("midrst_no_token", seen_q.size(), 0);

    // Random stream, digit-heavy to reach overflow and length saturation.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ch = 8'($urandom_range(48, 57));
        5:             ch = 8'h2D;
        6:             ch = 8'h20;
        7: begin
          case ($urandom_range(0, 2))
            0:       ch = 8'h09;
            1:       ch = 8'h0A;
            default: ch = 8'h0D;
          endcase
        end
        default:       ch = 8'($urandom_range(97, 122));
      endcase
      en = ($urandom_range(0, 4) != 0);
      drive(ch, en, (!en) && ($urandom_range(0, 3) == 0));
    end
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sniff_token_window.md
Name: sniff_token_window

Overview:
- Parametrised successor to the two-stage byte classifier plus 12-deep flag shift register in the sniffer datapath.
- Each enabled cycle it classifies one incoming ASCII byte and shifts it, with its flags, through a DEPTH-deep window.
- It also tracks signed decimal number tokens, converts each to binary and emits a one-cycle token report.
- Sits between the byte source and the downstream match/report logic.

Parameters:
- DEPTH, 12: window length in characters (≥2).
- VAL_W, 16: width of the unsigned token magnitude.
- LEN_W, 4: width of the digit-count field; saturates at 2^LEN_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  input byte valid; the block is frozen while low.
- flush  in  1  end of stream; sampled only when enable=0.
- data_in  in  8  ASCII byte.
- data_out  out  8  oldest byte in the window, win[DEPTH-1].
- is_number_out  out  DEPTH  digit flag per window slot; bit 0 is the newest byte.
- is_white_out  out  DEPTH  whitespace flag per window slot.
- tok_valid  out  1  one-cycle pulse marking a completed token.
- tok_value  out  VAL_W  token magnitude; saturates on overflow.
- tok_neg  out  1  token was preceded by '-'.
- tok_len  out  LEN_W  digit count, saturating; leading zeros count.
- tok_ovf  out  1  magnitude overflowed VAL_W.

Behaviour:
- Reset (asynchronous): window bytes and flags = 0, FSM = IDLE, accumulator = 0, and every output = 0.
- Classification (combinational on data_in):
  - digit: 0x30–0x39.
  - white: 0x20, 0x09, 0x0A, 0x0D.
  - sign: 0x2D.
- Window update on clk with enable=1:
  - slot 0 ← data_in and its flags; slot i ← slot i-1.
  - The new byte is visible at slot 0 one cycle after sampling and at data_out DEPTH cycles after sampling.
- enable=0: window, FSM and accumulator hold; tok_valid=0 unless a flush emits.
- FSM, evaluated only on enabled cycles unless noted:
  - IDLE: sign → SIGN. Digit → NUM with acc=d, len=1, neg=0, ovf=0. Anything else stays in IDLE.
  - SIGN: digit → NUM with acc=d, len=1, neg=1. Sign stays in SIGN. Other → IDLE. No token is emitted from SIGN.
  - NUM, digit: acc ← acc*10+d, computed at VAL_W+4 bits. If the result exceeds 2^VAL_W-1, acc saturates to all-ones and ovf is set sticky. len increments, saturating.
  - NUM, non-digit: emit the token. Next state is SIGN if the byte is '-' (with neg cleared for the new token), otherwise IDLE.
  - NUM, flush=1 while enable=0: emit the token, then go to IDLE.
  - SIGN, flush: go to IDLE, no token. IDLE, flush: no effect.
- Emit rules:
  - tok_valid=1 for exactly one cycle, registered, in the cycle after the terminating byte (or flush) is sampled.
  - tok_value, tok_neg, tok_len and tok_ovf load at the same edge and hold until the next emit.
- A terminating '-' both closes the current token and opens the next token in the same cycle.
- A reset asserted mid-token discards the token; no emit follows.
- "-0" emits value 0 with tok_neg=1; this is not normalised.

Decomposition:
- Shared package sniffer_pkg holds:
  - char constants: CH_0, CH_9, CH_SP, CH_TAB, CH_LF, CH_CR, CH_MINUS.
  - typedef enum tok_state_t {IDLE, SIGN, NUM}.
  - function classify(byte) returning a struct {is_number, is_white, is_sign}.
- One natural sub-module, sniff_char_classifier: a combinational byte-to-flags classifier, instanced once.
- The window and the token FSM live in the top module.

Test Plan:
- Reset, then stream "pp2p 1h3c  traas20-02540kkkk" with enable=1, one byte per cycle, DEPTH=12. Required tok_valid pulses, in order:
  - 2 (neg=0, len=1)
  - 1 (len=1)
  - 3 (len=1)
  - 20 (len=2, terminated by '-')
  - 2540 (neg=1, len=5)
  - No pulse for any letter or whitespace.
- Same stream: after byte 'p' at index 0 is sampled, data_out=0x70 exactly 12 enabled cycles later.
  - After byte '2' at index 2 is sampled, is_number_out[0]=1.
  - After ' ' at index 4 is sampled, is_white_out[0]=1.
- Stream "70000 " with VAL_W=16 → tok_value=0xFFFF, tok_ovf=1, len=5.
  - The next token "5 " → value 5, tok_ovf=0.
- Stream "--x-7" then enable=0 with flush=1:
  - No token for "--x".
  - Flush emits value 7, neg=1, len=1, with tok_valid one cycle after the flush cycle.
- Stream "12" with enable toggling 1,0,0,1 and then " " → token 12 emitted once; the window does not shift during the enable=0 cycles.
- Stream "45", assert rst asynchronously mid-cycle, then send " " → all outputs are 0 immediately on reset, and no token follows the space.
